// File: rtl/arrow_track_pkg.sv
// Shared constants for the arrow track: default geometry and lane bit order.
package arrow_track_pkg;

  localparam int NUM_LANES_DEF = 4;
  localparam int DEPTH_DEF     = 4;
  localparam int COMBO_W_DEF   = 8;

  // Lane bit positions inside a row mask
  typedef enum int {
    LANE_UP    = 0,
    LANE_DOWN  = 1,
    LANE_LEFT  = 2,
    LANE_RIGHT = 3
  } lane_e;

endpackage

// File: rtl/arrow_track_if.sv
// Chart-side inputs and judge/display-side outputs of the arrow track.
interface arrow_track_if
  import arrow_track_pkg::*;
#(
  parameter int NUM_LANES = NUM_LANES_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int COMBO_W   = COMBO_W_DEF
);
  logic                         step_i;
  logic [NUM_LANES-1:0]         next_row_i;
  logic [NUM_LANES-1:0]         press_i;
  logic                         pause_i;
  logic                         flush_i;
  logic [DEPTH*NUM_LANES-1:0]   rows_o;
  logic                         hit_o;
  logic [NUM_LANES-1:0]         hit_lanes_o;
  logic                         miss_o;
  logic [NUM_LANES-1:0]         miss_lanes_o;
  logic                         bad_o;
  logic [COMBO_W-1:0]           combo_o;

  modport master (
    output step_i, next_row_i, press_i, pause_i, flush_i,
    input  rows_o, hit_o, hit_lanes_o, miss_o, miss_lanes_o, bad_o, combo_o
  );

  modport slave (
    input  step_i, next_row_i, press_i, pause_i, flush_i,
    output rows_o, hit_o, hit_lanes_o, miss_o, miss_lanes_o, bad_o, combo_o
  );
endinterface

// File: rtl/arrow_track_judge.sv
// Combinational judge of one target row against the current presses.
module arrow_judge
  import arrow_track_pkg::*;
#(
  parameter int NUM_LANES = NUM_LANES_DEF
) (
  input  logic [NUM_LANES-1:0] tgt_i,
  input  logic [NUM_LANES-1:0] press_i,
  input  logic                 step_i,
  input  logic                 act_i,
  output logic [NUM_LANES-1:0] hit_o,
  output logic [NUM_LANES-1:0] bad_o,
  output logic [NUM_LANES-1:0] miss_o,
  output logic [NUM_LANES-1:0] clr_o
);

  // Masks are forced to zero outside active cycles so the event registers
  // simply capture them; a lane pressed on the departing row counts as a hit.
  always_comb begin
    hit_o  = '0;
    bad_o  = '0;
    miss_o = '0;
    if (act_i) begin
      hit_o = press_i & tgt_i;
      bad_o = press_i & ~tgt_i;
      if (step_i) miss_o = tgt_i & ~press_i;
    end
    clr_o = tgt_i & ~hit_o;
  end

endmodule

// File: rtl/arrow_track.sv
// Arrow row shift buffer with press judging, event pulses and combo counter.
module arrow_track
  import arrow_track_pkg::*;
#(
  parameter int NUM_LANES = NUM_LANES_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int COMBO_W   = COMBO_W_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  arrow_track_if.slave  bus
);

  logic [DEPTH-1:0][NUM_LANES-1:0] rows_q, rows_d;
  logic [COMBO_W-1:0]              combo_q, combo_d;
  logic                            hit_q, miss_q, bad_q;
  logic [NUM_LANES-1:0]            hit_lanes_q, miss_lanes_q;

  logic                 act;
  logic [NUM_LANES-1:0] hit_m, bad_m, miss_m, clr_m;

  assign act = !bus.pause_i && !bus.flush_i;

  arrow_judge #(.NUM_LANES(NUM_LANES)) u_judge (
    .tgt_i   (rows_q[DEPTH-1]),
    .press_i (bus.press_i),
    .step_i  (bus.step_i),
    .act_i   (act),
    .hit_o   (hit_m),
    .bad_o   (bad_m),
    .miss_o  (miss_m),
    .clr_o   (clr_m)
  );

  // Row update: flush clears, a step shifts toward the target, otherwise hit lanes drop out of the target
  always_comb begin
    rows_d = rows_q;
    if (bus.flush_i) begin
      rows_d = '0;
    end else if (act) begin
      if (bus.step_i) begin
        for (int r = 1; r < DEPTH; r++) rows_d[r] = rows_q[r-1];
        rows_d[0] = bus.next_row_i;
      end else begin
        rows_d[DEPTH-1] = clr_m;
      end
    end
  end

  // Combo: any miss/bad breaks it, otherwise one increment per hitting cycle, saturating
  always_comb begin
    combo_d = combo_q;
    if (bus.flush_i)                 combo_d = '0;
    else if (|miss_m || |bad_m)      combo_d = '0;
    else if (|hit_m && combo_q != '1) combo_d = combo_q + COMBO_W'(1);
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rows_q  <= '0;
      combo_q <= '0;
    end else begin
      rows_q  <= rows_d;
      combo_q <= combo_d;
    end
  end

  // Event registers; judge masks are already zero when not active
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_q        <= 1'b0;
      miss_q       <= 1'b0;
      bad_q        <= 1'b0;
      hit_lanes_q  <= '0;
      miss_lanes_q <= '0;
    end else begin
      hit_q        <= |hit_m;
      miss_q       <= |miss_m;
      bad_q        <= |bad_m;
      hit_lanes_q  <= hit_m;
      miss_lanes_q <= miss_m;
    end
  end

  assign bus.rows_o       = rows_q;
  assign bus.combo_o      = combo_q;
  assign bus.hit_o        = hit_q;
  assign bus.hit_lanes_o  = hit_lanes_q;
  assign bus.miss_o       = miss_q;
  assign bus.miss_lanes_o = miss_lanes_q;
  assign bus.bad_o        = bad_q;

endmodule

// File: tb/tb_arrow_track.sv
// Directed bench for arrow_track with an event scoreboard and monitor.
module tb_arrow_track;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  arrow_track_if #(.NUM_LANES(4), .DEPTH(4), .COMBO_W(8)) bus ();

  arrow_track #(.NUM_LANES(4), .DEPTH(4), .COMBO_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0] hit;
    logic [3:0] miss;
    logic       bad;
  } evt_t;

  evt_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [3:0] h, input logic [3:0] m, input logic b);
    evt_t e;
    e.hit = h; e.miss = m; e.bad = b;
    exp_q.push_back(e);
  endtask

  // One clock with the given inputs; returns #1 after the edge with inputs idle
  task automatic drive(input logic st, input logic [3:0] nr, input logic [3:0] pr,
                       input logic pa, input logic fl);
    bus.step_i = st; bus.next_row_i = nr; bus.press_i = pr;
    bus.pause_i = pa; bus.flush_i = fl;
    @(posedge clk); #1;
    bus.step_i = 1'b0; bus.next_row_i = '0; bus.press_i = '0;
    bus.pause_i = 1'b0; bus.flush_i = 1'b0;
  endtask

  task automatic chk_state(input string name, input logic [15:0] rows, input logic [7:0] combo);
    chk({name, ".rows"}, 32'(bus.rows_o), 32'(rows));
    chk({name, ".combo"}, 32'(bus.combo_o), 32'(combo));
  endtask

  // Monitor: every presented event pulse is matched against the next expected entry
  always @(negedge clk) begin
    if (rst_n && (bus.hit_o || bus.miss_o || bus.bad_o)) begin
      if (exp_q.size() == 0) begin
        chk("evt.unexpected", {bus.hit_lanes_o, bus.miss_lanes_o, 3'b0, bus.bad_o}, 32'h0);
      end else begin
        evt_t e;
        e = exp_q.pop_front();
        chk("evt.hit_o",        32'(bus.hit_o),        32'(|e.hit));
        chk("evt.hit_lanes_o",  32'(bus.hit_lanes_o),  32'(e.hit));
        chk("evt.miss_o",       32'(bus.miss_o),       32'(|e.miss));
        chk("evt.miss_lanes_o", 32'(bus.miss_lanes_o), 32'(e.miss));
        chk("evt.bad_o",        32'(bus.bad_o),        32'(e.bad));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.step_i = 1'b0; bus.next_row_i = '0; bus.press_i = '0;
    bus.pause_i = 1'b0; bus.flush_i = 1'b0;
    #1;
    chk_state("reset", 16'h0000, 8'd0);
    chk("reset.events", {bus.hit_o, bus.miss_o, bus.bad_o, bus.hit_lanes_o, bus.miss_lanes_o}, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Fill: departing rows are all empty, so no events
    drive(1, 4'b0001, 0, 0, 0);
    drive(1, 4'b0010, 0, 0, 0);
    drive(1, 4'b0100, 0, 0, 0);
    drive(1, 4'b1000, 0, 0, 0);
    chk_state("fill", 16'h1248, 8'd0);

    // Plain hits build the combo; cleared targets step out without a miss
    push(4'b0001, 0, 0); drive(0, 0, 4'b0001, 0, 0);       chk_state("hitA", 16'h0248, 8'd1);
    drive(1, 4'b0101, 0, 0, 0);                            chk_state("stepB", 16'h2485, 8'd1);
    push(4'b0010, 0, 0); drive(0, 0, 4'b0010, 0, 0);       chk_state("hitC", 16'h0485, 8'd2);
    drive(1, 4'b0000, 0, 0, 0);                            chk_state("stepD", 16'h4850, 8'd2);
    push(4'b0100, 0, 0); drive(0, 0, 4'b0100, 0, 0);       chk_state("hitE", 16'h0850, 8'd3);
    drive(1, 4'b0011, 0, 0, 0);                            chk_state("stepF", 16'h8503, 8'd3);
    push(4'b1000, 0, 0); drive(0, 0, 4'b1000, 0, 0);       chk_state("hitG", 16'h0503, 8'd4);
    drive(1, 4'b0000, 0, 0, 0);                            chk_state("stepH", 16'h5030, 8'd4);

    // Press with step on departing 0101: one lane hit, one lane missed, combo broken
    push(4'b0001, 4'b0100, 0); drive(1, 0, 4'b0001, 0, 0); chk_state("pstep", 16'h0300, 8'd0);
    drive(1, 4'b0000, 0, 0, 0);                            chk_state("stepJ", 16'h3000, 8'd0);
    push(4'b0001, 0, 0); drive(0, 0, 4'b0001, 0, 0);       chk_state("hitK", 16'h2000, 8'd1);

    // Wrong press: combo reset, target untouched
    push(0, 0, 1); drive(0, 0, 4'b1000, 0, 0);             chk_state("bad", 16'h2000, 8'd0);

    // Plain miss of an uncleared target
    push(0, 4'b0010, 0); drive(1, 4'b1111, 0, 0, 0);       chk_state("miss", 16'h000F, 8'd0);
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);                                  chk_state("fillF", 16'hF000, 8'd0);
    push(4'b0001, 0, 0); drive(0, 0, 4'b0001, 0, 0);       chk_state("hitF", 16'hE000, 8'd1);
    // Hit and bad together: bad wins the combo
    push(4'b0010, 0, 1); drive(0, 0, 4'b0011, 0, 0);       chk_state("hitbad", 16'hC000, 8'd0);
    push(4'b0100, 0, 0); drive(0, 0, 4'b0100, 0, 0);       chk_state("hitC2", 16'h8000, 8'd1);

    // Pause drops step and press; flush clears despite step/press
    drive(1, 4'b1111, 4'b1000, 1, 0);                      chk_state("pause", 16'h8000, 8'd1);
    drive(1, 4'b1111, 4'b1000, 1, 1);                      chk_state("flush", 16'h0000, 8'd0);

    // Saturation: fill with 0001, then step+press each cycle
    for (int i = 0; i < 4; i++) drive(1, 4'b0001, 0, 0, 0);
    chk_state("satfill", 16'h1111, 8'd0);
    for (int i = 0; i < 260; i++) begin
      push(4'b0001, 0, 0);
      drive(1, 4'b0001, 4'b0001, 0, 0);
      if (i == 253) chk("sat.254", 32'(bus.combo_o), 32'd254);
    end
    chk_state("sat", 16'h1111, 8'd255);
    drive(0, 0, 0, 0, 0);                                  chk_state("sathold", 16'h1111, 8'd255);

    // Asynchronous reset in the middle of a step cycle
    bus.step_i = 1'b1; bus.next_row_i = 4'b1111;
    #2 rst_n = 1'b0;
    #1;
    chk_state("areset", 16'h0000, 8'd0);
    chk("areset.events", {bus.hit_o, bus.miss_o, bus.bad_o, bus.hit_lanes_o, bus.miss_lanes_o}, 32'h0);
    bus.step_i = 1'b0; bus.next_row_i = '0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    chk("scoreboard.leftover", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
